// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared definitions:
// funct3 codes, FSM state encoding, default depth.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DMEM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_RESP = 2'd2
    } dmr_state_t;

endpackage

// File: rtl/dmem_load_align.sv
// Lane select, sign/zero extension and legality
// check for one data-memory access.
module dmem_load_align
    import dmem_responder_pkg::*;
#(
    parameter int MEM_WIDTH = 8,
    parameter int REG_WIDTH = 32
) (
    input  logic                   we,
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [4*MEM_WIDTH-1:0] raw,
    output logic [REG_WIDTH-1:0]   rdata,
    output logic [2:0]             size,
    output logic                   bad
);

    logic [MEM_WIDTH-1:0]   b;
    logic [2*MEM_WIDTH-1:0] h;

    assign b = raw[32'(addr_lo)*MEM_WIDTH +: MEM_WIDTH];
    assign h = addr_lo[1] ? raw[2*MEM_WIDTH +: 2*MEM_WIDTH]
                          : raw[0 +: 2*MEM_WIDTH];

    // Decode size/sign; stores only allow B/H/W.
    always_comb begin
        rdata = '0;
        size  = 3'd1;
        bad   = 1'b0;
        unique case (1'b1)
            (funct3 == F3_B): begin
                rdata = {{(REG_WIDTH-MEM_WIDTH){b[MEM_WIDTH-1]}}, b};
            end
            (funct3 == F3_H): begin
                size  = 3'd2;
                bad   = addr_lo[0];
                rdata = {{(REG_WIDTH-2*MEM_WIDTH){h[2*MEM_WIDTH-1]}}, h};
            end
            (funct3 == F3_W): begin
                size  = 3'd4;
                bad   = |addr_lo;
                rdata = REG_WIDTH'(raw);
            end
            (!we && funct3 == F3_BU): begin
                rdata = {{(REG_WIDTH-MEM_WIDTH){1'b0}}, b};
            end
            (!we && funct3 == F3_HU): begin
                size  = 3'd2;
                bad   = addr_lo[0];
                rdata = {{(REG_WIDTH-2*MEM_WIDTH){1'b0}}, h};
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in,
// fixed wait states, extended load data out.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_WIDTH       = 8,
    parameter int DMEM_ADDR_WIDTH = 32,
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_DEPTH      = DMEM_DEPTH_DEF,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [REG_WIDTH-1:0]       resp_rdata,
    output logic                       resp_err
);

    localparam int         IDX_W  = $clog2(DMEM_DEPTH);
    localparam int         AW1    = DMEM_ADDR_WIDTH + 1;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    dmr_state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       accept, enter_resp;

    logic                       l_we;
    logic [2:0]                 l_f3;
    logic [DMEM_ADDR_WIDTH-1:0] l_addr;
    logic [REG_WIDTH-1:0]       l_wdata;

    logic                       cur_we;
    logic [2:0]                 cur_f3;
    logic [DMEM_ADDR_WIDTH-1:0] cur_addr;
    logic [REG_WIDTH-1:0]       cur_wdata;

    logic [MEM_WIDTH-1:0]   mem [DMEM_DEPTH];
    logic [IDX_W-1:0]       base_idx;
    logic [4*MEM_WIDTH-1:0] raw;
    logic [REG_WIDTH-1:0]   al_rdata;
    logic [2:0]             al_size;
    logic                   al_bad;
    logic                   oor;
    logic                   err;

    assign req_ready  = (state == DMR_IDLE);
    assign resp_valid = (state == DMR_RESP);

    // With zero wait states the commit edge is the
    // accept edge, so use the live request then.
    assign cur_we    = req_ready ? req_we     : l_we;
    assign cur_f3    = req_ready ? req_funct3 : l_f3;
    assign cur_addr  = req_ready ? req_addr   : l_addr;
    assign cur_wdata = req_ready ? req_wdata  : l_wdata;

    assign base_idx = {cur_addr[IDX_W-1:2], 2'b00};

    for (genvar k = 0; k < 4; k++) begin : g_raw
        assign raw[k*MEM_WIDTH +: MEM_WIDTH] =
            mem[base_idx + IDX_W'(k)];
    end

    dmem_load_align #(
        .MEM_WIDTH (MEM_WIDTH),
        .REG_WIDTH (REG_WIDTH)
    ) u_align (
        .we      (cur_we),
        .funct3  (cur_f3),
        .addr_lo (cur_addr[1:0]),
        .raw     (raw),
        .rdata   (al_rdata),
        .size    (al_size),
        .bad     (al_bad)
    );

    assign oor = ({1'b0, cur_addr} + AW1'(al_size))
                 > AW1'(DMEM_DEPTH);
    assign err = al_bad | oor;

    // Next-state, wait counter and commit strobe.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            DMR_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_nx = '0;
                    if (WAIT_N == 4'd0) begin
                        state_nx   = DMR_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = DMR_WAIT;
                    end
                end
            end
            DMR_WAIT: begin
                if (cnt == WAIT_N) begin
                    state_nx   = DMR_RESP;
                    enter_resp = 1'b1;
                    cnt_nx     = '0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            DMR_RESP: begin
                if (resp_ready) state_nx = DMR_IDLE;
            end
            default: state_nx = DMR_IDLE;
        endcase
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DMR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request latch, loaded on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_we    <= 1'b0;
            l_f3    <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else if (accept) begin
            l_we    <= req_we;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
        end
    end

    // Response register, held until handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_rdata <= (cur_we | err) ? '0 : al_rdata;
            resp_err   <= err;
        end else if (resp_valid && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    // Byte storage; little-endian store commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++)
                mem[i] <= '0;
        end else if (enter_resp && cur_we && !err) begin
            for (int k = 0; k < 4; k++)
                if (3'(k) < al_size)
                    mem[cur_addr[IDX_W-1:0] + IDX_W'(k)] <=
                        cur_wdata[k*MEM_WIDTH +: MEM_WIDTH];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder
// against a byte-array reference model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    bit [7:0] mm [DEPTH];

    dmem_responder #(
        .MEM_WIDTH       (8),
        .DMEM_ADDR_WIDTH (32),
        .REG_WIDTH       (32),
        .DMEM_DEPTH      (DEPTH),
        .WAIT_CYCLES     (WAITC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic model(input bit we, input bit [2:0] f3,
                         input bit [31:0] addr,
                         input bit [31:0] wd,
                         output bit [31:0] rd,
                         output bit e);
        longint sz, a, v;
        bit legal;
        sz = (f3[1:0] == 2'd0) ? 1 :
             (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2)
                   : (f3 != 3'd3 && f3 < 3'd6);
        a = longint'(addr);
        e = !legal || (a % sz != 0) || (a + sz > DEPTH);
        rd = '0;
        if (e) return;
        if (we) begin
            for (longint i = 0; i < sz; i++)
                mm[a+i] = 8'((wd >> (8*i)) & 32'hFF);
        end else begin
            v = 0;
            for (longint i = 0; i < sz; i++)
                v += longint'(mm[a+i]) << (8*i);
            if (!f3[2] && sz < 4 &&
                v >= (longint'(1) << (8*sz-1)))
                v -= longint'(1) << (8*sz);
            rd = v[31:0];
        end
    endtask

    task automatic junk();
        req_valid  = 1'($urandom);
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic run(input string tag, input bit we,
                       input bit [2:0] f3,
                       input bit [31:0] addr,
                       input bit [31:0] wd,
                       input int hold,
                       output bit [31:0] rd,
                       output bit e);
        bit [31:0] mrd;
        bit me;
        int cyc;
        logic [31:0] rd0;
        logic e0;
        model(we, f3, addr, wd, mrd, me);
        rd = '0;
        e  = 1'b0;
        check({tag, ".rdy"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            junk();
            resp_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, cyc, WAITC + 1);
        if (!resp_valid) begin
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        rd0 = resp_rdata;
        e0  = resp_err;
        check({tag, ".data"}, rd0, mrd);
        check({tag, ".err"}, 32'(e0), 32'(me));
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            junk();
            req_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, ".bp_vld"}, 32'(resp_valid), 32'd1);
            check({tag, ".bp_rdy"}, 32'(req_ready), 32'd0);
            check({tag, ".bp_data"}, resp_rdata, rd0);
            check({tag, ".bp_err"}, 32'(resp_err), 32'(e0));
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({tag, ".done_vld"}, 32'(resp_valid), 32'd0);
        check({tag, ".done_rdy"}, 32'(req_ready), 32'd1);
        rd = rd0;
        e  = e0;
    endtask

    initial begin
        bit [31:0] rd;
        bit e;
        bit [31:0] addr;
        bit [2:0] f3;
        int r;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #1;
        check("rst_rdy", 32'(req_ready), 32'd1);
        check("rst_vld", 32'(resp_valid), 32'd0);
        check("rst_data", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run("lw0", 0, F3_W, 32'h0, 0, 0, rd, e);
        check("lw0_v", rd, 32'h0);
        run("sw10", 1, F3_W, 32'h10, 32'hDEADBEEF, 0, rd, e);
        run("lw10", 0, F3_W, 32'h10, 0, 0, rd, e);
        check("lw10_v", rd, 32'hDEADBEEF);
        run("lb13", 0, F3_B, 32'h13, 0, 0, rd, e);
        check("lb13_v", rd, 32'hFFFFFFDE);
        run("lbu13", 0, F3_BU, 32'h13, 0, 0, rd, e);
        check("lbu13_v", rd, 32'h000000DE);
        run("lh10", 0, F3_H, 32'h10, 0, 0, rd, e);
        check("lh10_v", rd, 32'hFFFFBEEF);
        run("lhu12", 0, F3_HU, 32'h12, 0, 0, rd, e);
        check("lhu12_v", rd, 32'h0000DEAD);
        run("sb11", 1, F3_B, 32'h11, 32'h12, 0, rd, e);
        run("lw10b", 0, F3_W, 32'h10, 0, 0, rd, e);
        check("lw10b_v", rd, 32'hDEAD12EF);

        run("e_lw12", 0, F3_W, 32'h12, 0, 0, rd, e);
        check("e_lw12_e", 32'(e), 32'd1);
        run("e_sh15", 1, F3_H, 32'h15, 32'hFFFF, 0, rd, e);
        check("e_sh15_e", 32'(e), 32'd1);
        run("e_sw3fe", 1, F3_W, 32'h3FE, 32'hCAFEBABE, 0, rd, e);
        check("e_sw3fe_e", 32'(e), 32'd1);
        run("e_f3_3", 0, 3'b011, 32'h10, 0, 0, rd, e);
        check("e_f3_3_e", 32'(e), 32'd1);
        check("e_f3_3_d", rd, 32'h0);
        run("lw14", 0, F3_W, 32'h14, 0, 0, rd, e);
        check("lw14_v", rd, 32'h0);
        run("lw3fc", 0, F3_W, 32'h3FC, 0, 0, rd, e);
        check("lw3fc_v", rd, 32'h0);
        run("lw10c", 0, F3_W, 32'h10, 0, 0, rd, e);
        check("lw10c_v", rd, 32'hDEAD12EF);

        run("bp", 0, F3_W, 32'h10, 0, 5, rd, e);
        check("bp_v", rd, 32'hDEAD12EF);

        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h20;
        req_wdata  = 32'h11223344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_wait_rdy", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(resp_valid), 32'd0);
        check("mid_rst_rdy", 32'(req_ready), 32'd1);
        check("mid_rst_data", resp_rdata, 32'd0);
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run("lw20", 0, F3_W, 32'h20, 0, 0, rd, e);
        check("lw20_v", rd, 32'h0);
        run("lw10z", 0, F3_W, 32'h10, 0, 0, rd, e);
        check("lw10z_v", rd, 32'h0);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       addr = $urandom_range(0, 63);
            else if (r < 8)  addr = $urandom_range(1016, 1023);
            else if (r == 8) addr = $urandom_range(1024, 1100);
            else             addr = $urandom;
            r = $urandom_range(0, 19);
            if (r < 17) begin
                r = $urandom_range(0, 4);
                f3 = (r < 3) ? 3'(r) : 3'(r + 1);
            end else begin
                f3 = 3'($urandom);
            end
            run("rnd", 1'($urandom), f3, addr, $urandom,
                $urandom_range(0, 3), rd, e);
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
